// File: rtl/axi_lite_access_master_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_access_master_if
// Purpose  : Bundles the command/response port and the AXI4-Lite master
//            channels of axi_lite_access_master.
// Modports : master - view of the access master (drives AXI valids, Cmd ready,
//                     response outputs)
//            slave  - view of the environment (command source + AXI slave)
// Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_access_master_if;
    // Command / response
    logic        CmdValid_ValIn;
    logic        CmdReady_RdyOut;
    logic        CmdWrite_EnIn;
    logic [31:0] CmdAddr_DatIn;
    logic [31:0] CmdData_DatIn;
    logic        RspValid_ValOut;
    logic [31:0] RspData_DatOut;
    logic [1:0]  RspResp_DatOut;
    logic        RspTimeout_EnOut;
    // AW
    logic        AxiWriteAddrValid_ValOut;
    logic        AxiWriteAddrReady_RdyIn;
    logic [31:0] AxiWriteAddrAddress_AdrOut;
    logic [2:0]  AxiWriteAddrProt_DatOut;
    // W
    logic        AxiWriteDataValid_ValOut;
    logic        AxiWriteDataReady_RdyIn;
    logic [31:0] AxiWriteDataData_DatOut;
    logic [3:0]  AxiWriteDataStrobe_DatOut;
    // B
    logic        AxiWriteRespValid_ValIn;
    logic        AxiWriteRespReady_RdyOut;
    logic [1:0]  AxiWriteRespResponse_DatIn;
    // AR
    logic        AxiReadAddrValid_ValOut;
    logic        AxiReadAddrReady_RdyIn;
    logic [31:0] AxiReadAddrAddress_AdrOut;
    logic [2:0]  AxiReadAddrProt_DatOut;
    // R
    logic        AxiReadDataValid_ValIn;
    logic        AxiReadDataReady_RdyOut;
    logic [31:0] AxiReadDataData_DatIn;
    logic [1:0]  AxiReadDataResponse_DatIn;

    modport master (
        input  CmdValid_ValIn, CmdWrite_EnIn, CmdAddr_DatIn, CmdData_DatIn,
        output CmdReady_RdyOut, RspValid_ValOut, RspData_DatOut, RspResp_DatOut, RspTimeout_EnOut,
        output AxiWriteAddrValid_ValOut, AxiWriteAddrAddress_AdrOut, AxiWriteAddrProt_DatOut,
        input  AxiWriteAddrReady_RdyIn,
        output AxiWriteDataValid_ValOut, AxiWriteDataData_DatOut, AxiWriteDataStrobe_DatOut,
        input  AxiWriteDataReady_RdyIn,
        input  AxiWriteRespValid_ValIn, AxiWriteRespResponse_DatIn,
        output AxiWriteRespReady_RdyOut,
        output AxiReadAddrValid_ValOut, AxiReadAddrAddress_AdrOut, AxiReadAddrProt_DatOut,
        input  AxiReadAddrReady_RdyIn,
        input  AxiReadDataValid_ValIn, AxiReadDataData_DatIn, AxiReadDataResponse_DatIn,
        output AxiReadDataReady_RdyOut
    );

    modport slave (
        output CmdValid_ValIn, CmdWrite_EnIn, CmdAddr_DatIn, CmdData_DatIn,
        input  CmdReady_RdyOut, RspValid_ValOut, RspData_DatOut, RspResp_DatOut, RspTimeout_EnOut,
        input  AxiWriteAddrValid_ValOut, AxiWriteAddrAddress_AdrOut, AxiWriteAddrProt_DatOut,
        output AxiWriteAddrReady_RdyIn,
        input  AxiWriteDataValid_ValOut, AxiWriteDataData_DatOut, AxiWriteDataStrobe_DatOut,
        output AxiWriteDataReady_RdyIn,
        output AxiWriteRespValid_ValIn, AxiWriteRespResponse_DatIn,
        input  AxiWriteRespReady_RdyOut,
        input  AxiReadAddrValid_ValOut, AxiReadAddrAddress_AdrOut, AxiReadAddrProt_DatOut,
        output AxiReadAddrReady_RdyIn,
        output AxiReadDataValid_ValIn, AxiReadDataData_DatIn, AxiReadDataResponse_DatIn,
        input  AxiReadDataReady_RdyOut
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_access_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_access_master
// Purpose  : Turns single register read/write commands into AXI4-Lite
//            transactions, one outstanding at a time, with a cycle timeout.
// Ports    : SysClk_ClkIn  - clock, rising edge
//            SysRstN_RstIn - asynchronous active-low reset
//            bus           - command/response + AXI4-Lite master channels
// Params   : TimeoutCycles_Gen - cycles from command acceptance to abort
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_access_master #(
    parameter int unsigned TimeoutCycles_Gen = 65535
) (
    input  wire logic               SysClk_ClkIn,
    input  wire logic               SysRstN_RstIn,
    axi_lite_access_master_if.master bus
);

    localparam logic [31:0] c_limit = 32'(TimeoutCycles_Gen);

    typedef enum logic [1:0] {
        Idle_St  = 2'd0,
        Read_St  = 2'd1,
        Write_St = 2'd2,
        Resp_St  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic        r_cmdready;
    logic        r_rspvalid;
    logic [31:0] r_rspdata;
    logic [1:0]  r_rspresp;
    logic        r_rsptimeout;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_araddr;

    logic w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_both_done, w_limit;

    assign w_cmd_hs    = bus.CmdValid_ValIn & r_cmdready;
    assign w_aw_hs     = r_awvalid & bus.AxiWriteAddrReady_RdyIn;
    assign w_w_hs      = r_wvalid  & bus.AxiWriteDataReady_RdyIn;
    assign w_b_hs      = r_bready  & bus.AxiWriteRespValid_ValIn;
    assign w_ar_hs     = r_arvalid & bus.AxiReadAddrReady_RdyIn;
    assign w_r_hs      = r_rready  & bus.AxiReadDataValid_ValIn;
    // Counts this cycle's handshakes so BREADY rises right after the later of AW/W.
    assign w_both_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    // The counter reaches the limit on this edge.
    assign w_limit     = (r_cnt + 32'd1) >= c_limit;

    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            r_state      <= Idle_St;
            r_cnt        <= '0;
            r_cmdready   <= 1'b1;
            r_rspvalid   <= 1'b0;
            r_rspdata    <= '0;
            r_rspresp    <= '0;
            r_rsptimeout <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_araddr     <= '0;
        end else begin
            case (r_state)
                Idle_St: begin
                    if (w_cmd_hs) begin
                        r_cmdready <= 1'b0;
                        r_cnt      <= '0;
                        if (bus.CmdWrite_EnIn) begin
                            r_state   <= Write_St;
                            r_awaddr  <= bus.CmdAddr_DatIn;
                            r_wdata   <= bus.CmdData_DatIn;
                            r_wstrb   <= 4'hF;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end else begin
                            r_state   <= Read_St;
                            r_araddr  <= bus.CmdAddr_DatIn;
                            r_arvalid <= 1'b1;
                        end
                    end
                end

                Read_St, Write_St: begin
                    // A completing handshake beats the timeout on the same edge.
                    if (w_b_hs || w_r_hs) begin
                        r_state      <= Resp_St;
                        r_bready     <= 1'b0;
                        r_rready     <= 1'b0;
                        r_rspvalid   <= 1'b1;
                        r_rsptimeout <= 1'b0;
                        r_rspresp    <= w_r_hs ? bus.AxiReadDataResponse_DatIn
                                               : bus.AxiWriteRespResponse_DatIn;
                        r_rspdata    <= w_r_hs ? bus.AxiReadDataData_DatIn : 32'd0;
                    end else if (w_limit) begin
                        r_state      <= Resp_St;
                        r_awvalid    <= 1'b0;
                        r_wvalid     <= 1'b0;
                        r_bready     <= 1'b0;
                        r_arvalid    <= 1'b0;
                        r_rready     <= 1'b0;
                        r_rspvalid   <= 1'b1;
                        r_rsptimeout <= 1'b1;
                        r_rspresp    <= 2'b10;
                        r_rspdata    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                        if (r_state == Write_St) begin
                            if (w_aw_hs) begin
                                r_awvalid <= 1'b0;
                                r_aw_done <= 1'b1;
                            end
                            if (w_w_hs) begin
                                r_wvalid <= 1'b0;
                                r_w_done <= 1'b1;
                            end
                            if (w_both_done) begin
                                r_bready <= 1'b1;
                            end
                        end else if (w_ar_hs) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                        end
                    end
                end

                Resp_St: begin
                    r_state      <= Idle_St;
                    r_rspvalid   <= 1'b0;
                    r_rsptimeout <= 1'b0;
                    r_cmdready   <= 1'b1;
                end

                default: begin
                    r_state <= Idle_St;
                end
            endcase
        end
    end

    assign bus.CmdReady_RdyOut            = r_cmdready;
    assign bus.RspValid_ValOut            = r_rspvalid;
    assign bus.RspData_DatOut             = r_rspdata;
    assign bus.RspResp_DatOut             = r_rspresp;
    assign bus.RspTimeout_EnOut           = r_rsptimeout;
    assign bus.AxiWriteAddrValid_ValOut   = r_awvalid;
    assign bus.AxiWriteAddrAddress_AdrOut = r_awaddr;
    assign bus.AxiWriteAddrProt_DatOut    = 3'b000;
    assign bus.AxiWriteDataValid_ValOut   = r_wvalid;
    assign bus.AxiWriteDataData_DatOut    = r_wdata;
    assign bus.AxiWriteDataStrobe_DatOut  = r_wstrb;
    assign bus.AxiWriteRespReady_RdyOut   = r_bready;
    assign bus.AxiReadAddrValid_ValOut    = r_arvalid;
    assign bus.AxiReadAddrAddress_AdrOut  = r_araddr;
    assign bus.AxiReadAddrProt_DatOut     = 3'b000;
    assign bus.AxiReadDataReady_RdyOut    = r_rready;

endmodule
`default_nettype wire

// File: doc/axi_lite_access_master.md
AXI_LITE_ACCESS_MASTER -- requirements
Module: axi_lite_access_master

Interface
REQ-001 Parameter TimeoutCycles_Gen, default 65535: cycles allowed from transaction start to completion before abort.
REQ-002 SysClk_ClkIn  in  1  system clock; all logic on its rising edge.
REQ-003 SysRstN_RstIn  in  1  reset; asynchronous, active-low.
REQ-004 CmdValid_ValIn  in  1  command request.
REQ-005 CmdReady_RdyOut  out  1  command accepted when both Valid and Ready are high.
REQ-006 CmdWrite_EnIn  in  1  1 = write, 0 = read.
REQ-007 CmdAddr_DatIn  in  32  register address.
REQ-008 CmdData_DatIn  in  32  write data.
REQ-009 RspValid_ValOut  out  1  one-cycle completion pulse.
REQ-010 RspData_DatOut  out  32  read data, 0 for writes and timeouts.
REQ-011 RspResp_DatOut  out  2  AXI response code.
REQ-012 RspTimeout_EnOut  out  1  qualifies RspValid; transaction aborted by timeout.
REQ-013 AXI4-Lite master ports:
- AW channel: AxiWriteAddrValid_ValOut, AxiWriteAddrReady_RdyIn, AxiWriteAddrAddress_AdrOut[31:0], AxiWriteAddrProt_DatOut[2:0].
- W channel: AxiWriteDataValid_ValOut, AxiWriteDataReady_RdyIn, AxiWriteDataData_DatOut[31:0], AxiWriteDataStrobe_DatOut[3:0].
- B channel: AxiWriteRespValid_ValIn, AxiWriteRespReady_RdyOut, AxiWriteRespResponse_DatIn[1:0].
- AR channel: AxiReadAddrValid_ValOut, AxiReadAddrReady_RdyIn, AxiReadAddrAddress_AdrOut[31:0], AxiReadAddrProt_DatOut[2:0].
- R channel: AxiReadDataValid_ValIn, AxiReadDataReady_RdyOut, AxiReadDataData_DatIn[31:0], AxiReadDataResponse_DatIn[1:0].

Function
REQ-014 States Idle_St, Read_St, Write_St, Resp_St; exactly one transaction outstanding.
REQ-015 CmdReady = 1 only in Idle_St.
- Accepted write -> Write_St.
- Accepted read -> Read_St.
- Address and data are registered on acceptance.
REQ-016 Cycle after acceptance of a write: AWVALID and WVALID both 1, with registered address/data, WSTRB = 4'hF, PROT = 3'b000.
REQ-017 AWVALID and WVALID each drop the cycle after their own handshake, independently; a same-cycle handshake on both is legal.
REQ-018 After both AW and W handshakes, BREADY = 1 until the B handshake.
- A BVALID arriving before both AW and W handshakes is not accepted.
REQ-019 Cycle after acceptance of a read: ARVALID = 1 until the AR handshake, then RREADY = 1 until the R handshake; RDATA/RRESP captured then.
REQ-020 Valid/address outputs stay stable while VALID is high and READY is low.
REQ-021 Cycle after the B or R handshake: Resp_St with RspValid = 1 for one cycle, RspResp = captured BRESP/RRESP, RspTimeout = 0; then Idle_St.
REQ-022 Minimum latency is 3 cycles from Cmd handshake to RspValid when the slave is always ready and responds in the cycle after the address handshake.
REQ-023 Timeout counter:
- 16+ bits; cleared on Cmd acceptance; increments each cycle in Read_St or Write_St.
- On reaching TimeoutCycles_Gen: deassert all AXI VALID/READY next cycle, enter Resp_St, RspResp = 2'b10, RspTimeout = 1, RspData = 0.
REQ-024 A handshake completing in the same cycle the counter reaches the limit takes precedence; the transaction completes normally.
REQ-025 SLVERR/DECERR/EXOKAY responses are passed through unmodified; no retry.
REQ-026 RspData and RspResp hold their values until the next RspValid.

Reset
REQ-027 While SysRstN_RstIn = 0:
- State Idle_St, counter 0.
- All VALID/READY outputs 0 except CmdReady = 1.
- RspValid 0, RspTimeout 0.
- RspData, RspResp and all AXI address/data outputs 0.
REQ-028 Reset asserted mid-transaction aborts it immediately without a response pulse; the first command after release starts a fresh transaction.

Verification
REQ-029 Write 0x0000_0010 <= 0xDEADBEEF, AWREADY/WREADY/BVALID = 1 (BRESP 00) -> AW/W carry the values with WSTRB F; RspValid 3 cycles after Cmd, RspResp 00.
REQ-030 Read 0x0000_0004, ARREADY delayed 5 cycles, RDATA 0x12345678 / RRESP 00 -> ARVALID held stable 6 cycles; RspData 0x12345678.
REQ-031 Write with WREADY 4 cycles before AWREADY -> WVALID drops first, AWVALID held; BREADY only after both handshakes; single RspValid.
REQ-032 TimeoutCycles_Gen = 16, slave never ready -> all VALIDs drop after 16 cycles; RspResp 10, RspTimeout 1, RspData 0; CmdReady returns.
REQ-033 Read returns RRESP 10 -> RspResp 10, RspTimeout 0; then back-to-back commands are accepted with one outstanding each.
REQ-034 Reset pulsed during Read_St with ARVALID high -> ARVALID 0 asynchronously, no RspValid, next read completes normally.
